emmc_ddr_rx_ctrl: RTL and testbench
===================================

EMMC_DDR_RX_CTRL -- requirements
Module: emmc_ddr_rx_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, data bytes per block; even, 4..4096.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clocks spent waiting for the start bit.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle pulse that arms reception of one block.
REQ-006 SHALL have port iddr_Q1  in  8  DAT[7:0] sampled on the rising edge.
REQ-007 SHALL have port iddr_Q2  in  8  DAT[7:0] sampled on the falling edge.
REQ-008 SHALL have port fifo_full  in  1  downstream FIFO full.
REQ-009 SHALL have port fifo_data_out  out  32  packed data word.
REQ-010 SHALL have port fifo_wr_en  out  1  one-cycle write strobe for fifo_data_out.
REQ-011 SHALL have port busy  out  1  high from an accepted start until done.
REQ-012 SHALL have port done  out  1  one-cycle pulse at block end.
REQ-013 SHALL have port err  out  3  sticky flags {crc_err, overflow_err, timeout_err}, valid at done.

Function
REQ-014 SHALL implement states IDLE, WAIT_START, DATA, CRC, END_BIT, DONE.
REQ-015 IDLE: start SHALL go to WAIT_START, clear err, and set busy; start in any other state SHALL be ignored.
REQ-016 WAIT_START: iddr_Q1==8'h00 SHALL go to DATA; the timeout counter reaching TIMEOUT_CYCLES first SHALL set timeout_err and go to DONE.
REQ-017 DATA: each clock SHALL take two bytes, Q1 then Q2, and run for BLOCK_BYTES/2 clocks.
REQ-018 Packing SHALL be big-endian: first clock Q1->[31:24], Q2->[23:16]; second clock Q1->[15:8], Q2->[7:0].
REQ-019 fifo_wr_en SHALL pulse in the cycle after every second DATA clock, with fifo_data_out stable in that cycle.
REQ-020 If fifo_full is high when fifo_wr_en would assert, the strobe SHALL be suppressed, the word dropped, overflow_err set, and reception SHALL continue, since the card cannot be stalled.
REQ-021 CRC: SHALL consume exactly 16 clocks (16 CRC bits per line per edge), then go to END_BIT.
REQ-022 END_BIT: iddr_Q1 != 8'hFF SHALL set crc_err; the FSM SHALL always go to DONE.
REQ-023 DONE: SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-024 The byte counter SHALL be $clog2(BLOCK_BYTES)+1 bits wide and SHALL not wrap within a block.
REQ-025 DATA-state latency SHALL be one clock from the second byte pair to fifo_wr_en.

Reset
REQ-026 Reset SHALL force IDLE at any clock, including mid-block; no further strobes SHALL follow.
REQ-027 Reset values SHALL be: fifo_data_out=0, fifo_wr_en=0, busy=0, done=0, err=0, counters 0.

Configuration
REQ-028 With CRC_CHECK_EN defined, the block SHALL run 16 serial CRC-16 engines (one per line per edge, x^16+x^12+x^5+1, seed 0) over DATA bits, compare them with the received CRC bits, and set crc_err on any mismatch.
REQ-029 Without CRC_CHECK_EN, no CRC engines SHALL be built; CRC bits SHALL be skipped and crc_err SHALL flag only a bad end bit.

Structure
REQ-030 Package emmc_rx_pkg SHALL hold the state enum, the CRC16 polynomial constant, the CRC length (16), and the err bit indices.
REQ-031 SHALL use one sub-module, crc16_serial (1-bit input, enable, clear, 16-bit remainder), instantiated 16 times under CRC_CHECK_EN.

Verification
REQ-032 Nominal block: start, 3 idle clocks, Q1=00 start bit, 256 clocks of an incrementing byte pattern, correct CRC, end FF -> 128 strobes, first word 0x00010203, last 0xFCFDFEFF, done with err=000.
REQ-033 Timeout with TIMEOUT_CYCLES=100: start, bus held at FF -> done at clock 101, err=001, no strobes.
REQ-034 Overflow: fifo_full high during words 10-12 -> 125 strobes, words 10-12 missing, err=010 at done.
REQ-035 CRC fault (CRC_CHECK_EN): flip one CRC bit on DAT3 falling edge -> err=100; same stimulus without the macro -> err=000.
REQ-036 Reset mid-DATA after 40 clocks -> next cycle IDLE, all outputs 0; a new start then receives a full block correctly.

Source files
------------

// File: rtl/emmc_rx_pkg.sv
// Shared types and constants for the eMMC DDR block receiver.
package emmc_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT,
        DONE
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          CRC_LEN    = 16;

    localparam int ERR_CRC = 2;
    localparam int ERR_OVF = 1;
    localparam int ERR_TMO = 0;

endpackage

// File: rtl/emmc_ddr_rx_ctrl_crc16_serial.sv
// Bit-serial CRC-16 (x^16+x^12+x^5+1), MSB first, seed 0.
module crc16_serial
    import emmc_rx_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;

    assign fb = din ^ crc[15];

    always_ff @(posedge clock) begin
        if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/emmc_ddr_rx_ctrl.sv
// eMMC 8-bit DDR single-block receiver: packs DAT bytes into 32-bit FIFO words.
// Optional per-line CRC-16 checking is enabled by defining CRC_CHECK_EN.
module emmc_ddr_rx_ctrl
    import emmc_rx_pkg::*;
#(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iddr_Q1,
    input  logic [7:0]  iddr_Q2,
    input  logic        fifo_full,
    output logic [31:0] fifo_data_out,
    output logic        fifo_wr_en,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err
);

    localparam int BW = $clog2(BLOCK_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_PAIR = BW'(BLOCK_BYTES - 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    ccnt;
    logic [15:0]   hi_half;
    logic          crc_bad;

`ifdef CRC_CHECK_EN
    // Engines 0..7 follow DAT[7:0] rising-edge bits, 8..15 the falling-edge bits.
    // The received CRC is shifted in too, so a clean block leaves every remainder zero.
    logic [15:0] crc_din;
    logic [15:0] crc_rem [16];
    logic        crc_en;
    logic        crc_clr;

    assign crc_din = {iddr_Q2, iddr_Q1};
    assign crc_en  = (state == DATA) || (state == CRC);
    assign crc_clr = (state == IDLE) && start;

    for (genvar g = 0; g < 16; g++) begin : g_crc
        crc16_serial u_crc (
            .clock (clock),
            .clear (crc_clr),
            .en    (crc_en),
            .din   (crc_din[g]),
            .crc   (crc_rem[g])
        );
    end

    always_comb begin
        crc_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (crc_rem[i] != 16'h0000) crc_bad = 1'b1;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    // Upper half of the word is held until the second byte pair arrives.
    always_ff @(posedge clock) begin
        if (state == DATA && !bcnt[1]) hi_half <= {iddr_Q1, iddr_Q2};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bcnt          <= '0;
            tcnt          <= '0;
            ccnt          <= '0;
            fifo_data_out <= '0;
            fifo_wr_en    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_START;
                        busy  <= 1'b1;
                        err   <= '0;
                        tcnt  <= '0;
                        bcnt  <= '0;
                        ccnt  <= '0;
                    end
                end
                WAIT_START: begin
                    if (iddr_Q1 == 8'h00) begin
                        state <= DATA;
                    end else if (tcnt == TMO_LAST) begin
                        err[ERR_TMO] <= 1'b1;
                        state        <= DONE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DATA: begin
                    bcnt <= bcnt + BW'(2);
                    // The card cannot be stalled: a full FIFO costs the word, not the block.
                    if (bcnt[1]) begin
                        fifo_data_out <= {hi_half, iddr_Q1, iddr_Q2};
                        if (fifo_full) err[ERR_OVF] <= 1'b1;
                        else           fifo_wr_en   <= 1'b1;
                    end
                    if (bcnt == LAST_PAIR) state <= CRC;
                end
                CRC: begin
                    ccnt <= ccnt + 4'd1;
                    if (ccnt == 4'(CRC_LEN - 1)) state <= END_BIT;
                end
                END_BIT: begin
                    if (iddr_Q1 != 8'hFF || crc_bad) err[ERR_CRC] <= 1'b1;
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_ddr_rx_ctrl.sv
// Randomized self-checking bench for emmc_ddr_rx_ctrl against a word/CRC reference model.
module tb_emmc_ddr_rx_ctrl;

    localparam int BB    = 512;
    localparam int TMO   = 100;
    localparam int NCLK  = BB / 2;
    localparam int NWORD = BB / 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fifo_full = 1'b0;
    logic [7:0]  iddr_Q1 = 8'hFF;
    logic [7:0]  iddr_Q2 = 8'hFF;
    logic [31:0] fifo_data_out;
    logic        fifo_wr_en;
    logic        busy;
    logic        done;
    logic [2:0]  err;

    emmc_ddr_rx_ctrl #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TMO)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .iddr_Q1       (iddr_Q1),
        .iddr_Q2       (iddr_Q2),
        .fifo_full     (fifo_full),
        .fifo_data_out (fifo_data_out),
        .fifo_wr_en    (fifo_wr_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [7:0]  blk [BB];
    logic [15:0] crc_exp [16];
    logic [31:0] got [$];
    logic [31:0] expq [$];
    int          full_lo  = -1;
    int          full_hi  = -2;
    int          flip_eng = -1;
    int          flip_bit = 0;
    logic [7:0]  end_byte = 8'hFF;
    bit          glitch   = 1'b0;

    always @(negedge clock) begin
        if (fifo_wr_en) got.push_back(fifo_data_out);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC of one line/edge bit stream by polynomial long division of M(x)*x^16.
    function automatic logic [15:0] crc_ref(input int eng);
        bit          m [NCLK + 16];
        logic [16:0] gen;
        logic [15:0] r;
        gen = 17'h11021;
        for (int c = 0; c < NCLK; c++) m[c] = blk[2 * c + eng / 8][eng % 8];
        for (int c = NCLK; c < NCLK + 16; c++) m[c] = 1'b0;
        for (int i = 0; i < NCLK; i++) begin
            if (m[i]) begin
                for (int j = 0; j < 17; j++) m[i + j] = m[i + j] ^ gen[16 - j];
            end
        end
        for (int j = 0; j < 16; j++) r[15 - j] = m[NCLK + j];
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
    endtask

    task automatic send_block(input int idle, input int n_clk);
        start = 1'b1; iddr_Q1 = 8'hFF; iddr_Q2 = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        repeat (idle) @(negedge clock);
        iddr_Q1 = 8'h00;
        @(negedge clock);
        for (int c = 0; c < n_clk; c++) begin
            iddr_Q1   = blk[2 * c];
            iddr_Q2   = blk[2 * c + 1];
            fifo_full = (c / 2 >= full_lo) && (c / 2 <= full_hi);
            start     = glitch && (c == 50);
            if (c == 1) chk_eq("busy_in_data", 32'(busy), 32'h1);
            @(negedge clock);
        end
        start = 1'b0; fifo_full = 1'b0;
        if (n_clk < NCLK) return;
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 8; l++) begin
                iddr_Q1[l] = crc_exp[l][15 - k] ^ (flip_eng == l && flip_bit == k);
                iddr_Q2[l] = crc_exp[8 + l][15 - k] ^ (flip_eng == 8 + l && flip_bit == k);
            end
            @(negedge clock);
        end
        iddr_Q1 = end_byte; iddr_Q2 = 8'hFF;
        @(negedge clock);
        iddr_Q1 = 8'hFF;
    endtask

    task automatic wait_done(input int limit, output logic [2:0] e);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk_eq("done_seen", 32'(done), 32'h1);
        e = err;
        chk_eq("busy_at_done", 32'(busy), 32'h0);
        @(negedge clock);
        chk_eq("done_one_cycle", 32'(done), 32'h0);
    endtask

    task automatic run_full(input int idle, input logic [2:0] exp_err);
        logic [2:0] e;
        for (int i = 0; i < 16; i++) crc_exp[i] = crc_ref(i);
        expq.delete();
        for (int w = 0; w < NWORD; w++) begin
            if (!(w >= full_lo && w <= full_hi))
                expq.push_back({blk[4 * w], blk[4 * w + 1], blk[4 * w + 2], blk[4 * w + 3]});
        end
        got.delete();
        send_block(idle, NCLK);
        wait_done(40, e);
        chk_eq("strobes", 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) chk_eq("word", got[i], expq[i]);
        chk_eq("err", 32'(e), 32'(exp_err));
    endtask

    initial begin
        int          n;
        logic [31:0] w0;
        logic [31:0] wl;
        logic [2:0]  crc_fault_err;

        repeat (3) @(negedge clock);
        chk_eq("rst_data", fifo_data_out, 32'h0);
        chk_eq("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk_eq("rst_busy", 32'(busy), 32'h0);
        chk_eq("rst_done", 32'(done), 32'h0);
        chk_eq("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Nominal incrementing-pattern block
        for (int i = 0; i < BB; i++) blk[i] = 8'(i);
        run_full(3, 3'b000);
        w0 = (got.size() > 0) ? got[0] : 32'hDEADBEEF;
        wl = (got.size() > 0) ? got[got.size() - 1] : 32'hDEADBEEF;
        chk_eq("first_word", w0, 32'h00010203);
        chk_eq("last_word", wl, 32'hFCFDFEFF);
        chk_eq("nom_strobes", 32'(got.size()), 32'd128);

        // Start-bit timeout with the bus parked high
        got.delete();
        start = 1'b1; iddr_Q1 = 8'hFF; n = 0;
        while (n < 200) begin
            @(negedge clock);
            start = 1'b0;
            n++;
            if (done) break;
        end
        chk_eq("tmo_cycle", 32'(n), 32'd101);
        chk_eq("tmo_err", 32'(err), 32'h1);
        chk_eq("tmo_strobes", 32'(got.size()), 32'h0);
        @(negedge clock);

        // Overflow on words 10..12
        fill_random();
        full_lo = 10; full_hi = 12;
        run_full(int'($urandom_range(0, 20)), 3'b010);
        chk_eq("ovf_strobes", 32'(got.size()), 32'd125);
        for (int r = 0; r < 2; r++) begin
            fill_random();
            full_lo = int'($urandom_range(0, NWORD - 6));
            full_hi = full_lo + int'($urandom_range(0, 4));
            run_full(int'($urandom_range(0, 20)), 3'b010);
        end
        full_lo = -1; full_hi = -2;

        // One CRC bit flipped on DAT3 falling edge
`ifdef CRC_CHECK_EN
        crc_fault_err = 3'b100;
`else
        crc_fault_err = 3'b000;
`endif
        fill_random();
        flip_eng = 11; flip_bit = int'($urandom_range(0, 15));
        run_full(int'($urandom_range(0, 20)), crc_fault_err);
        flip_eng = -1;

        // Bad end bit
        fill_random();
        end_byte = 8'hFE;
        run_full(2, 3'b100);
        end_byte = 8'hFF;

        // Random clean blocks, with a stray start mid-block that must be ignored
        glitch = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_full(int'($urandom_range(0, 20)), 3'b000);
        end
        glitch = 1'b0;

        // Reset in the middle of DATA
        fill_random();
        got.delete();
        send_block(2, 40);
        reset = 1'b1;
        @(negedge clock);
        chk_eq("pre_reset_strobes", 32'(got.size()), 32'd20);
        chk_eq("mid_rst_data", fifo_data_out, 32'h0);
        chk_eq("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk_eq("mid_rst_busy", 32'(busy), 32'h0);
        chk_eq("mid_rst_done", 32'(done), 32'h0);
        chk_eq("mid_rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iddr_Q1 = 8'($urandom); iddr_Q2 = 8'($urandom);
            @(negedge clock);
        end
        chk_eq("post_reset_strobes", 32'(got.size()), 32'd20);
        fill_random();
        run_full(int'($urandom_range(0, 20)), 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got 0 expected finish");
        $fatal(1);
    end

endmodule
